gpio2: RTL and testbench
========================

GPIO2 -- requirements
Module: gpio2

Interface
REQ-001 SHALL have parameter N_PADS, default 16, number of pads (1..32).
REQ-002 SHALL have parameter W_FSEL, default 2, function-select width per pad; N_FUNCS = 2**W_FSEL.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-004 SHALL have port clk, input, 1, sole clock; all flops on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have ports apbs_psel/apbs_penable/apbs_pwrite, input, 1 each, APB control.
REQ-007 SHALL have ports apbs_paddr (input, 16) and apbs_pwdata (input, 32), APB address and write data.
REQ-008 SHALL have ports apbs_prdata (output, 32), apbs_pready (output, 1) and apbs_pslverr (output, 1), APB response.
REQ-009 SHALL have ports padout and padoe (output, N_PADS), pad drive and enable.
REQ-010 SHALL have port padin, input, N_PADS, asynchronous pad inputs.
REQ-011 SHALL have ports per_out and per_oe, input, N_PADS*(N_FUNCS-1), peripheral drive; pad i, function j>=1 uses bit i*(N_FUNCS-1)+j-1.
REQ-012 SHALL have port per_in, output, N_PADS, synchronised pad values to peripherals.
REQ-013 SHALL have port irq, output, 1, level interrupt.

Function
REQ-014 Register map (byte offsets) SHALL be: 0x00 OUT rw; 0x04 OUT_SET wo; 0x08 OUT_CLR wo; 0x0C OUT_XOR wo; 0x10 OE rw; 0x14 IN ro; 0x18 RISE_EN rw; 0x1C FALL_EN rw; 0x20 STATUS rw1c; 0x40+4*i FSEL[i] rw (bits W_FSEL-1:0).
REQ-015 apbs_pready SHALL be tied 1; writes commit on the clock edge where psel&penable&pwrite.
REQ-016 apbs_pslverr SHALL be 1 during access phase to any unmapped offset, or to FSEL[i] with i>=N_PADS; such writes have no effect.
REQ-017 apbs_prdata SHALL be combinational; unused bits and write-only registers read 0.
REQ-018 OUT_SET/CLR/XOR SHALL perform OUT|=d, OUT&=~d, OUT^=d in one cycle.
REQ-019 Pad i with FSEL=0 SHALL drive padout=OUT[i], padoe=OE[i]; with FSEL=j>0 it SHALL drive per_out/per_oe bit j; the mux is combinational.
REQ-020 padin SHALL pass through SYNC_STAGES flops; IN and per_in SHALL equal the last stage, visible SYNC_STAGES edges after padin changes.
REQ-021 The edge detector SHALL register the last sync stage (prev); rise = sync&~prev, fall = ~sync&prev.
REQ-022 STATUS[i] SHALL set on the edge after rise&RISE_EN[i] or fall&FALL_EN[i], i.e. SYNC_STAGES+1 edges after padin changes.
REQ-023 A W1C write and a set event on the same bit in the same cycle SHALL leave the bit set.
REQ-024 irq SHALL be registered: irq = |STATUS, one cycle after STATUS updates.
REQ-025 Edge detection and IN SHALL operate regardless of FSEL.

Reset
REQ-026 With rst high at a clock edge, OUT, OE, RISE_EN, FALL_EN, STATUS, all FSEL, all sync stages, prev and irq SHALL become 0.
REQ-027 Reset SHALL override any concurrent APB write or edge event in that cycle.
REQ-028 The first edge after reset with a pad held high SHALL produce rise, latched only if RISE_EN is already set.

Structure
REQ-029 Register offsets, N_FUNCS derivation and the FSEL base SHALL live in shared header gpio2_pkg.
REQ-030 The synchroniser SHALL be sub-module gpio2_sync (parameter DEPTH, WIDTH, sync reset).

Verification
REQ-031 Write OUT=0x00F0, OUT_SET=0x0003, OUT_CLR=0x0010, OUT_XOR=0x8001 -> OUT reads 0x80E2.
REQ-032 OE=0x0001, FSEL[0]=2, per_out bit 1 = 1, per_oe bit 1 = 1 -> padout[0]=1, padoe[0]=1; FSEL[0]=0 -> padout[0]=OUT[0].
REQ-033 RISE_EN=0x4, padin[2] 0->1 at edge k -> IN[2]=1 at k+2, STATUS=0x4 at k+3, irq=1 at k+4.
REQ-034 FALL_EN=0x1, fall event coinciding with STATUS W1C 0x1 -> STATUS[0] stays 1; next W1C without event -> 0, irq 0 one cycle later.
REQ-035 Read 0x30 and FSEL[16] with N_PADS=16 -> pslverr=1, prdata=0, no state change.
REQ-036 rst asserted mid-pending interrupt with APB write -> all registers 0, irq 0 next cycle.

Source files
------------

// File: rtl/gpio2_pkg.sv
// Shared register map, field widths and decode helpers for the gpio2 block.
package gpio2_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] OFF_OUT     = 16'h0000;
  localparam logic [ADDR_W-1:0] OFF_OUT_SET = 16'h0004;
  localparam logic [ADDR_W-1:0] OFF_OUT_CLR = 16'h0008;
  localparam logic [ADDR_W-1:0] OFF_OUT_XOR = 16'h000C;
  localparam logic [ADDR_W-1:0] OFF_OE      = 16'h0010;
  localparam logic [ADDR_W-1:0] OFF_IN      = 16'h0014;
  localparam logic [ADDR_W-1:0] OFF_RISE_EN = 16'h0018;
  localparam logic [ADDR_W-1:0] OFF_FALL_EN = 16'h001C;
  localparam logic [ADDR_W-1:0] OFF_STATUS  = 16'h0020;
  localparam logic [ADDR_W-1:0] FSEL_BASE   = 16'h0040;

  typedef enum logic [3:0] {
    SEL_NONE, SEL_OUT, SEL_OUT_SET, SEL_OUT_CLR, SEL_OUT_XOR, SEL_OE,
    SEL_IN, SEL_RISE_EN, SEL_FALL_EN, SEL_STATUS, SEL_FSEL
  } reg_sel_e;

  function automatic int unsigned n_funcs(input int unsigned w_fsel);
    return 32'd1 << w_fsel;
  endfunction

  // Fixed-offset part of the map; the FSEL window is decoded by the top.
  function automatic reg_sel_e decode_fixed(input logic [ADDR_W-1:0] addr);
    case (addr)
      OFF_OUT:     return SEL_OUT;
      OFF_OUT_SET: return SEL_OUT_SET;
      OFF_OUT_CLR: return SEL_OUT_CLR;
      OFF_OUT_XOR: return SEL_OUT_XOR;
      OFF_OE:      return SEL_OE;
      OFF_IN:      return SEL_IN;
      OFF_RISE_EN: return SEL_RISE_EN;
      OFF_FALL_EN: return SEL_FALL_EN;
      OFF_STATUS:  return SEL_STATUS;
      default:     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio2_if.sv
// APB slave bus bundle for gpio2.
interface gpio2_if;
  import gpio2_pkg::*;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/gpio2_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs, synchronous reset.
module gpio2_sync #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/gpio2.sv
// GPIO block: APB register file, per-pad function mux, synchronised inputs
// with rise/fall edge capture into a sticky STATUS register and level irq.
module gpio2
  import gpio2_pkg::*;
#(
  parameter int unsigned N_PADS      = 16,
  parameter int unsigned W_FSEL      = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  gpio2_if.slave                                     apbs,
  output logic [N_PADS-1:0]                          padout,
  output logic [N_PADS-1:0]                          padoe,
  input  logic [N_PADS-1:0]                          padin,
  input  logic [N_PADS*(n_funcs(W_FSEL)-1)-1:0]      per_out,
  input  logic [N_PADS*(n_funcs(W_FSEL)-1)-1:0]      per_oe,
  output logic [N_PADS-1:0]                          per_in,
  output logic                                       irq
);

  localparam int unsigned N_FUNCS = n_funcs(W_FSEL);

  logic [N_PADS-1:0]              out_q, oe_q, rise_en_q, fall_en_q, status_q, prev_q;
  logic [N_PADS-1:0][W_FSEL-1:0] fsel_q;
  logic [N_PADS-1:0]              sync_q, set_ev, w1c, wdata;
  logic [ADDR_W-1:0]              fsel_idx;
  logic [DATA_W-1:0]              rdata;
  reg_sel_e                       sel;
  logic                           access, wr;
  logic                           unused_wdata;

  assign access       = apbs.psel & apbs.penable;
  assign wr           = access & apbs.pwrite;
  assign wdata        = apbs.pwdata[N_PADS-1:0];
  assign unused_wdata = ^apbs.pwdata;

  // Unaligned offsets and FSEL slots beyond the last pad decode as unmapped.
  always_comb begin
    fsel_idx = ADDR_W'((apbs.paddr - FSEL_BASE) >> 2);
    sel      = SEL_NONE;
    if (apbs.paddr[1:0] == 2'b00) begin
      sel = decode_fixed(apbs.paddr);
      if (apbs.paddr >= FSEL_BASE && fsel_idx < ADDR_W'(N_PADS)) sel = SEL_FSEL;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_OUT:     rdata = DATA_W'(out_q);
      SEL_OE:      rdata = DATA_W'(oe_q);
      SEL_IN:      rdata = DATA_W'(sync_q);
      SEL_RISE_EN: rdata = DATA_W'(rise_en_q);
      SEL_FALL_EN: rdata = DATA_W'(fall_en_q);
      SEL_STATUS:  rdata = DATA_W'(status_q);
      SEL_FSEL: begin
        for (int i = 0; i < N_PADS; i++)
          if (fsel_idx == ADDR_W'(i)) rdata = DATA_W'(fsel_q[i]);
      end
      default: rdata = '0;
    endcase
  end

  assign apbs.prdata  = rdata;
  assign apbs.pready  = 1'b1;
  assign apbs.pslverr = access & (sel == SEL_NONE);

  gpio2_sync #(.DEPTH(SYNC_STAGES), .WIDTH(N_PADS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (padin),
    .q   (sync_q)
  );

  assign per_in = sync_q;
  assign set_ev = (sync_q & ~prev_q & rise_en_q) | (~sync_q & prev_q & fall_en_q);
  assign w1c    = (wr && sel == SEL_STATUS) ? wdata : '0;

  // A new edge event wins over a same-cycle W1C on that bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      fsel_q    <= '0;
      prev_q    <= '0;
      irq       <= 1'b0;
    end else begin
      prev_q   <= sync_q;
      status_q <= (status_q & ~w1c) | set_ev;
      irq      <= |status_q;
      if (wr) begin
        case (sel)
          SEL_OUT:     out_q     <= wdata;
          SEL_OUT_SET: out_q     <= out_q | wdata;
          SEL_OUT_CLR: out_q     <= out_q & ~wdata;
          SEL_OUT_XOR: out_q     <= out_q ^ wdata;
          SEL_OE:      oe_q      <= wdata;
          SEL_RISE_EN: rise_en_q <= wdata;
          SEL_FALL_EN: fall_en_q <= wdata;
          SEL_FSEL: begin
            for (int i = 0; i < N_PADS; i++)
              if (fsel_idx == ADDR_W'(i)) fsel_q[i] <= apbs.pwdata[W_FSEL-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Function 0 is the GPIO register path; function j selects peripheral bit j-1 of the pad.
  always_comb begin
    padout = out_q;
    padoe  = oe_q;
    for (int i = 0; i < N_PADS; i++) begin
      for (int j = 1; j < N_FUNCS; j++) begin
        if (fsel_q[i] == W_FSEL'(j)) begin
          padout[i] = per_out[i*(N_FUNCS-1)+j-1];
          padoe[i]  = per_oe[i*(N_FUNCS-1)+j-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio2.sv
// Directed bench for gpio2: register-map vector table plus timed sequences
// for edge capture, W1C/event collision and reset override.
module tb_gpio2;

  localparam int unsigned NP = 16;
  localparam int unsigned PW = NP * 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] padout, padoe, padin, per_in;
  logic [PW-1:0] per_out, per_oe;
  logic          irq;

  int total = 0;
  int bad   = 0;

  gpio2_if apbs ();

  gpio2 #(.N_PADS(NP), .W_FSEL(2), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .apbs    (apbs),
    .padout  (padout),
    .padoe   (padoe),
    .padin   (padin),
    .per_out (per_out),
    .per_oe  (per_oe),
    .per_in  (per_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] a, input logic w, input logic [31:0] d,
                     input logic [31:0] er, input logic ee);
    vec_t v;
    v.addr = a; v.wr = w; v.wdata = d; v.exp_rd = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic apb_xfer(input logic [15:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output logic err);
    @(negedge clk);
    apbs.psel = 1'b1; apbs.penable = 1'b0; apbs.pwrite = w;
    apbs.paddr = a;   apbs.pwdata = d;
    @(negedge clk);
    apbs.penable = 1'b1;
    #1;
    rd  = apbs.prdata;
    err = apbs.pslverr;
    @(posedge clk);
    #1;
    apbs.psel = 1'b0; apbs.penable = 1'b0; apbs.pwrite = 1'b0;
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        err;
    apb_xfer(a, 1'b1, d, rd, err);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        err;
    apb_xfer(a, 1'b0, 32'h0, rd, err);
    chk(name, rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [31:0] exp_st [1:4];
    logic        exp_in [1:4];
    logic        exp_irq[1:4];

    rst = 1'b1;
    padin = '0; per_out = '0; per_oe = '0;
    apbs.psel = 1'b0; apbs.penable = 1'b0; apbs.pwrite = 1'b0;
    apbs.paddr = '0; apbs.pwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset padout", 32'(padout), 32'h0);
    chk("reset padoe",  32'(padoe),  32'h0);
    chk("reset irq",    32'(irq),    32'h0);
    chk("reset per_in", 32'(per_in), 32'h0);
    chk("pready tied",  32'(apbs.pready), 32'h1);

    // Register map vectors
    add(16'h0000, 1'b0, 32'h0,         32'h0,         1'b0);
    add(16'h0010, 1'b0, 32'h0,         32'h0,         1'b0);
    add(16'h0020, 1'b0, 32'h0,         32'h0,         1'b0);
    add(16'h0040, 1'b0, 32'h0,         32'h0,         1'b0);
    add(16'h0000, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b0);
    add(16'h0000, 1'b0, 32'h0,         32'h0000_FFFF, 1'b0);
    add(16'h0000, 1'b1, 32'h0000_00F0, 32'h0,         1'b0);
    add(16'h0004, 1'b1, 32'h0000_0003, 32'h0,         1'b0);
    add(16'h0008, 1'b1, 32'h0000_0010, 32'h0,         1'b0);
    add(16'h000C, 1'b1, 32'h0000_8001, 32'h0,         1'b0);
    add(16'h0000, 1'b0, 32'h0,         32'h0000_80E2, 1'b0);
    add(16'h0004, 1'b0, 32'h0,         32'h0,         1'b0);
    add(16'h0030, 1'b1, 32'h0000_1234, 32'h0,         1'b1);
    add(16'h0030, 1'b0, 32'h0,         32'h0,         1'b1);
    add(16'h0000, 1'b0, 32'h0,         32'h0000_80E2, 1'b0);
    add(16'h0080, 1'b1, 32'h0000_0003, 32'h0,         1'b1);
    add(16'h0080, 1'b0, 32'h0,         32'h0,         1'b1);
    add(16'h0040, 1'b0, 32'h0,         32'h0,         1'b0);
    add(16'h007C, 1'b0, 32'h0,         32'h0,         1'b0);
    add(16'h004C, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b0);
    add(16'h004C, 1'b0, 32'h0,         32'h0000_0003, 1'b0);
    add(16'h0018, 1'b1, 32'h0000_ABCD, 32'h0,         1'b0);
    add(16'h0018, 1'b0, 32'h0,         32'h0000_ABCD, 1'b0);
    add(16'h001C, 1'b0, 32'h0,         32'h0,         1'b0);
    add(16'h0010, 1'b1, 32'h0000_0001, 32'h0,         1'b0);
    add(16'h0010, 1'b0, 32'h0,         32'h0000_0001, 1'b0);
    add(16'h0014, 1'b0, 32'h0,         32'h0,         1'b0);

    for (int v = 0; v < vecs.size(); v++) begin
      apb_xfer(vecs[v].addr, vecs[v].wr, vecs[v].wdata, rd, err);
      chk($sformatf("vec%0d pslverr", v), 32'(err), 32'(vecs[v].exp_err));
      if (!vecs[v].wr) chk($sformatf("vec%0d rdata", v), rd, vecs[v].exp_rd);
    end

    // Function mux: pad0 FSEL=2 -> bit 1, pad3 FSEL=3 -> bit 11
    per_out = '0; per_oe = '0;
    per_out[1] = 1'b1; per_oe[1] = 1'b1; per_out[11] = 1'b1;
    wr_reg(16'h0040, 32'h2);
    chk("fsel2 padout0", 32'(padout[0]), 32'h1);
    chk("fsel2 padoe0",  32'(padoe[0]),  32'h1);
    chk("fsel3 padout3", 32'(padout[3]), 32'h1);
    chk("fsel3 padoe3",  32'(padoe[3]),  32'h0);
    wr_reg(16'h0040, 32'h1);
    chk("fsel1 padout0", 32'(padout[0]), 32'h0);
    chk("fsel1 padoe0",  32'(padoe[0]),  32'h0);
    wr_reg(16'h0040, 32'h0);
    chk("fsel0 padout0", 32'(padout[0]), 32'h0);
    chk("fsel0 padoe0",  32'(padoe[0]),  32'h1);
    chk("fsel0 padout1", 32'(padout[1]), 32'h1);

    // Rise on pad 2: IN at k+2, STATUS at k+3, irq at k+4
    wr_reg(16'h0018, 32'h4);
    @(negedge clk);
    apbs.psel = 1'b1; apbs.penable = 1'b0; apbs.pwrite = 1'b0; apbs.paddr = 16'h0020;
    @(negedge clk);
    apbs.penable = 1'b1;
    @(posedge clk);
    #1 padin[2] = 1'b1;
    exp_in[1] = 1'b0; exp_st[1] = 32'h0; exp_irq[1] = 1'b0;
    exp_in[2] = 1'b1; exp_st[2] = 32'h0; exp_irq[2] = 1'b0;
    exp_in[3] = 1'b1; exp_st[3] = 32'h4; exp_irq[3] = 1'b0;
    exp_in[4] = 1'b1; exp_st[4] = 32'h4; exp_irq[4] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rise k+%0d per_in2", c), 32'(per_in[2]), 32'(exp_in[c]));
      chk($sformatf("rise k+%0d status", c), apbs.prdata, exp_st[c]);
      chk($sformatf("rise k+%0d irq", c), 32'(irq), 32'(exp_irq[c]));
    end
    apbs.psel = 1'b0; apbs.penable = 1'b0;
    rd_chk("IN after rise", 16'h0014, 32'h4);
    wr_reg(16'h0020, 32'h4);
    rd_chk("status after w1c", 16'h0020, 32'h0);
    chk("irq after w1c", 32'(irq), 32'h0);

    // Fall event on pad 0 colliding with W1C of the same bit
    wr_reg(16'h0018, 32'h0);
    wr_reg(16'h001C, 32'h1);
    padin[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rd_chk("status rise not enabled", 16'h0020, 32'h0);
    @(posedge clk);
    #1 padin[0] = 1'b0;
    @(posedge clk);
    wr_reg(16'h0020, 32'h1);
    rd_chk("status w1c vs event", 16'h0020, 32'h1);
    chk("irq after collision", 32'(irq), 32'h1);
    wr_reg(16'h0020, 32'h1);
    chk("irq lags clear", 32'(irq), 32'h1);
    @(posedge clk);
    #1;
    chk("irq cleared", 32'(irq), 32'h0);
    rd_chk("status cleared", 16'h0020, 32'h0);

    // Reset mid-pending interrupt with a concurrent APB write
    wr_reg(16'h0018, 32'h2);
    padin[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("irq pending", 32'(irq), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    apbs.psel = 1'b1; apbs.penable = 1'b1; apbs.pwrite = 1'b1;
    apbs.paddr = 16'h0000; apbs.pwdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apbs.psel = 1'b0; apbs.penable = 1'b0; apbs.pwrite = 1'b0;
    chk("rst irq",    32'(irq),    32'h0);
    chk("rst padout", 32'(padout), 32'h0);
    chk("rst padoe",  32'(padoe),  32'h0);
    chk("rst per_in", 32'(per_in), 32'h0);
    @(posedge clk);
    #1;
    chk("rst irq next", 32'(irq), 32'h0);
    rd_chk("rst OUT",     16'h0000, 32'h0);
    rd_chk("rst OE",      16'h0010, 32'h0);
    rd_chk("rst RISE_EN", 16'h0018, 32'h0);
    rd_chk("rst FALL_EN", 16'h001C, 32'h0);
    rd_chk("rst FSEL3",   16'h004C, 32'h0);
    rd_chk("rst STATUS",  16'h0020, 32'h0);
    rd_chk("rst IN",      16'h0014, 32'h6);
    chk("post rst irq", 32'(irq), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
